key_event_decoder: RTL and testbench

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

---
 rtl/key_pkg.sv | 20 ++
 rtl/key_edge_detect.sv | 26 ++
 rtl/key_event_decoder.sv | 126 ++++++++++++
 tb/tb_key_event_decoder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and defaults for the key event decoder.
package key_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_LONG_HELD,
    ST_WAIT_SECOND,
    ST_SECOND_PRESSED
  } key_state_e;

  localparam int unsigned LONG_CNT_DEF   = 50_000_000;
  localparam int unsigned DBL_CNT_DEF    = 12_500_000;
  localparam int unsigned REPEAT_CNT_DEF = 5_000_000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Registers the key level once and flags press/release edges (key_i vs key_q).
module key_edge_detect #(
  parameter logic KEY_ACTIVE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic pressed_o,
  output logic rise_o,
  output logic fall_o
);

  logic key_q;

  always_ff @(posedge clk) begin
    if (!rst_n) key_q <= ~KEY_ACTIVE;
    else        key_q <= key_i;
  end

  always_comb begin
    pressed_o = (key_i == KEY_ACTIVE);
    rise_o    = (key_i == KEY_ACTIVE) && (key_q != KEY_ACTIVE);
    fall_o    = (key_i != KEY_ACTIVE) && (key_q == KEY_ACTIVE);
  end

endmodule

// File: rtl/key_event_decoder.sv
// Click/long/double/auto-repeat decoder for a debounced key.
// Auto-repeat is built only when KEY_REPEAT_EN is defined.
module key_event_decoder #(
  parameter logic        KEY_ACTIVE = 1'b1,
  parameter int unsigned LONG_CNT   = key_pkg::LONG_CNT_DEF,
  parameter int unsigned DBL_CNT    = key_pkg::DBL_CNT_DEF,
  parameter int unsigned REPEAT_CNT = key_pkg::REPEAT_CNT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic press_o,
  output logic release_o,
  output logic short_o,
  output logic long_o,
  output logic double_o,
  output logic repeat_o,
  output logic key_state_o
);
  import key_pkg::*;

  localparam int unsigned CW = $clog2(max_u(max_u(LONG_CNT, DBL_CNT), REPEAT_CNT)) + 1;

  logic          pressed, rise, fall;
  key_state_e    state_q;
  logic [CW-1:0] cnt_q, cnt_d;

  key_edge_detect #(.KEY_ACTIVE(KEY_ACTIVE)) u_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_i     (key_i),
    .pressed_o (pressed),
    .rise_o    (rise),
    .fall_o    (fall)
  );

  // Saturating increment; every state change overrides this with zero.
  always_comb begin
    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      press_o     <= 1'b0;
      release_o   <= 1'b0;
      short_o     <= 1'b0;
      long_o      <= 1'b0;
      double_o    <= 1'b0;
      key_state_o <= 1'b0;
`ifdef KEY_REPEAT_EN
      repeat_o    <= 1'b0;
`endif
    end else begin
      press_o     <= rise;
      release_o   <= fall;
      short_o     <= 1'b0;
      long_o      <= 1'b0;
      double_o    <= 1'b0;
      key_state_o <= pressed;
      cnt_q       <= cnt_d;
`ifdef KEY_REPEAT_EN
      repeat_o    <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_q <= ST_PRESSED;
            cnt_q   <= '0;
          end
        end
        ST_PRESSED: begin
          if (fall) begin
            state_q <= ST_WAIT_SECOND;
            cnt_q   <= '0;
          end else if (cnt_q == CW'(LONG_CNT - 1)) begin
            long_o  <= 1'b1;
            state_q <= ST_LONG_HELD;
            cnt_q   <= '0;
          end
        end
        ST_LONG_HELD: begin
          if (fall) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
`ifdef KEY_REPEAT_EN
          // Counter restarts at each repeat so pulses stay REPEAT_CNT apart.
          else if (cnt_q == CW'(REPEAT_CNT - 1)) begin
            repeat_o <= 1'b1;
            cnt_q    <= '0;
          end
`endif
        end
        ST_WAIT_SECOND: begin
          // A press on the final window cycle still counts as the second click.
          if (rise) begin
            state_q <= ST_SECOND_PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == CW'(DBL_CNT - 1)) begin
            short_o <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        end
        ST_SECOND_PRESSED: begin
          if (fall) begin
            double_o <= 1'b1;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifndef KEY_REPEAT_EN
  assign repeat_o = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_decoder.sv
// Randomized and directed check of key_event_decoder against a timestamp-based model.
module tb_key_event_decoder;

  localparam int unsigned LONG = 50;
  localparam int unsigned DBL  = 30;
  localparam int unsigned REP  = 10;
`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_i = 1'b0;
  logic press_o, release_o, short_o, long_o, double_o, repeat_o, key_state_o;

  always #10 clk = ~clk;

  key_event_decoder #(
    .KEY_ACTIVE (1'b1),
    .LONG_CNT   (LONG),
    .DBL_CNT    (DBL),
    .REPEAT_CNT (REP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_i       (key_i),
    .press_o     (press_o),
    .release_o   (release_o),
    .short_o     (short_o),
    .long_o      (long_o),
    .double_o    (double_o),
    .repeat_o    (repeat_o),
    .key_state_o (key_state_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: click sequence tracked by press count and edge timestamps.
  logic [6:0] exp_v = '0;
  bit         started = 1'b0;
  longint     n = 0;
  bit         prev = 1'b0;
  int         presses = 0;
  bit         held = 1'b0, longed = 1'b0;
  longint     t = 0;

  always @(posedge clk) begin
    bit r, f;
    logic [6:0] e;
    n++;
    started = 1'b1;
    e = '0;
    if (!rst_n) begin
      prev = 1'b0; presses = 0; held = 1'b0; longed = 1'b0;
    end else begin
      r = key_i && !prev;
      f = !key_i && prev;
      prev = key_i;
      e[6] = r;
      e[5] = f;
      e[0] = key_i;
      if (presses == 0) begin
        if (r) begin presses = 1; held = 1'b1; longed = 1'b0; t = n; end
      end else if (longed) begin
        if (f) presses = 0;
        else if (REP_EN && ((n - t) % REP == 0)) e[1] = 1'b1;
      end else if (presses == 1 && held) begin
        if (f) begin held = 1'b0; t = n; end
        else if (n - t == LONG) begin e[3] = 1'b1; longed = 1'b1; t = n; end
      end else if (presses == 1) begin
        if (r) presses = 2;
        else if (n - t == DBL) begin e[4] = 1'b1; presses = 0; end
      end else begin
        if (f) begin e[2] = 1'b1; presses = 0; end
      end
    end
    exp_v = e;
  end

  // Per-cycle compare and DUT pulse bookkeeping for the directed checks.
  int cyc = 0;
  int n_press = 0, n_rel = 0, n_short = 0, n_long = 0, n_dbl = 0, n_rep = 0;
  int c_press = 0, c_rel = 0, c_short = 0, c_long = 0, c_dbl = 0;

  always @(negedge clk) begin
    logic [6:0] act;
    cyc++;
    act = {press_o, release_o, short_o, long_o, double_o, repeat_o, key_state_o};
    if (started) begin
      total++;
      if (act !== exp_v) begin
        bad++;
        $display("FAIL outputs cyc=%0d: got %b expected %b (press,rel,short,long,dbl,rep,state)",
                 cyc, act, exp_v);
      end
    end
    if (press_o   === 1'b1) begin n_press++; c_press = cyc; end
    if (release_o === 1'b1) begin n_rel++;   c_rel   = cyc; end
    if (short_o   === 1'b1) begin n_short++; c_short = cyc; end
    if (long_o    === 1'b1) begin n_long++;  c_long  = cyc; end
    if (double_o  === 1'b1) begin n_dbl++;   c_dbl   = cyc; end
    if (repeat_o  === 1'b1) n_rep++;
  end

  task automatic hold(input bit lvl, input int cycles);
    key_i = lvl;
    repeat (cycles) begin @(posedge clk); #2; end
  endtask

  int p0, r0, s0, l0, d0, q0;
  task automatic snap();
    p0 = n_press; r0 = n_rel; s0 = n_short; l0 = n_long; d0 = n_dbl; q0 = n_rep;
  endtask

  initial begin
    rst_n = 1'b0;
    key_i = 1'b0;
    repeat (3) begin @(posedge clk); #2; end
    check("reset_press", press_o, 0);
    check("reset_state", key_state_o, 0);
    rst_n = 1'b1;
    hold(0, 5);

    // Single short click
    snap();
    hold(1, 10); hold(0, 40);
    check("short_cnt", n_short - s0, 1);
    check("short_delay", c_short - c_rel, DBL);
    check("short_nolong", (n_long - l0) + (n_dbl - d0), 0);

    // Double click
    snap();
    hold(1, 5); hold(0, 10); hold(1, 5); hold(0, 40);
    check("dbl_press", n_press - p0, 2);
    check("dbl_rel", n_rel - r0, 2);
    check("dbl_cnt", n_dbl - d0, 1);
    check("dbl_with_rel", c_dbl, c_rel);
    check("dbl_noshort", n_short - s0, 0);

    // Long hold
    snap();
    hold(1, 80); hold(0, 40);
    check("long_cnt", n_long - l0, 1);
    check("long_delay", c_long - c_press, LONG);
    check("long_repeat", n_rep - q0, REP_EN ? 2 : 0);
    check("long_noshort", (n_short - s0) + (n_dbl - d0), 0);

    // Press exactly on the last window cycle wins
    snap();
    hold(1, 5); hold(0, DBL); hold(1, 5); hold(0, 40);
    check("edge_dbl", n_dbl - d0, 1);
    check("edge_noshort", n_short - s0, 0);

    // Press one cycle after the window: two separate short clicks
    snap();
    hold(1, 5); hold(0, DBL + 1); hold(1, 5); hold(0, 40);
    check("late_short", n_short - s0, 2);
    check("late_nodbl", n_dbl - d0, 0);

    // Hold boundary: LONG cycles is still short, LONG+1 is long
    snap();
    hold(1, LONG); hold(0, 40);
    check("bound_nolong", n_long - l0, 0);
    check("bound_short", n_short - s0, 1);
    snap();
    hold(1, LONG + 1); hold(0, 40);
    check("bound_long", n_long - l0, 1);

    // Reset during PRESSED with key held through reset
    snap();
    hold(1, 10);
    rst_n = 1'b0;
    hold(1, 5);
    check("rst_outs", {press_o, release_o, short_o, long_o, double_o, repeat_o, key_state_o}, 0);
    check("rst_nopulse", (n_short - s0) + (n_long - l0) + (n_dbl - d0) + (n_rel - r0), 0);
    rst_n = 1'b1;
    snap();
    hold(1, 10);
    check("rst_repress", n_press - p0, 1);
    hold(0, 5); hold(1, 5);
    check("rst_press2", n_press - p0, 2);
    hold(0, 60);

    // Randomized traffic including threshold-adjacent durations and resets
    for (int i = 0; i < 150; i++) begin
      int d;
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
        rst_n = 1'b1;
      end
      case ($urandom_range(0, 3))
        0:       d = int'($urandom_range(DBL - 2, DBL + 2));
        1:       d = int'($urandom_range(LONG - 2, LONG + 2));
        default: d = int'($urandom_range(1, 90));
      endcase
      hold(~key_i, d);
    end
    hold(0, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
